// File: rtl/mcycle_pkg.sv
// rtl/mcycle_pkg.sv - shared op codes and FSM states for the multi-cycle mul/div unit
package mcycle_pkg;

  // MCycleOp encodings, shared with the decoder stage
  localparam logic [1:0] MC_SMUL = 2'b00;
  localparam logic [1:0] MC_UMUL = 2'b01;
  localparam logic [1:0] MC_SDIV = 2'b10;
  localparam logic [1:0] MC_UDIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mc_state_e;

endpackage

// File: rtl/mcycle_iter_core.sv
// rtl/mcycle_iter_core.sv - one shift-add multiply or restoring divide step
module mcycle_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div_i,
  // MUL: {high accumulator, multiplier}; DIV: {remainder, quotient}
  input  logic [2*WIDTH-1:0]   acc_i,
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             trial_neg;
  logic [WIDTH-1:0] trial_diff;

  // Next accumulator value for a single iteration
  always_comb begin
    // Add the multiplicand into the high half when the multiplier LSB is set,
    // keeping the carry so the right shift brings it back in
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    if (acc_i[0]) begin
      mul_sum = mul_sum + {1'b0, operand_i};
    end

    // The shifted remainder can exceed WIDTH bits, so the trial is done at
    // WIDTH+1 bits; a non-negative difference always fits back into WIDTH bits
    rem_sh     = acc_i[2*WIDTH-1:WIDTH-1];
    trial_neg  = (rem_sh < {1'b0, operand_i});
    trial_diff = rem_sh[WIDTH-1:0] - operand_i;

    if (is_div_i) begin
      if (trial_neg) begin
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {trial_diff, acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mcycle_sequencer.sv
// rtl/mcycle_sequencer.sv - multi-cycle multiply/divide sequencer with pipeline stall
module mcycle_sequencer
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               sign_q, sign_d;
  logic               rsign_q, rsign_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   result1_q, result1_d;
  logic [WIDTH-1:0]   result2_q, result2_d;

  logic               op_is_div, op_signed;
  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mcycle_iter_core #(.WIDTH(WIDTH)) u_iter_core (
    .is_div_i  (is_div_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (acc_step)
  );

  // Operand decode and sign correction of the final iteration's value
  always_comb begin
    op_is_div = (MCycleOp == MC_SDIV) || (MCycleOp == MC_UDIV);
    op_signed = (MCycleOp == MC_SMUL) || (MCycleOp == MC_SDIV);
    sign1     = op_signed & Operand1[WIDTH-1];
    sign2     = op_signed & Operand2[WIDTH-1];
    mag1      = sign1 ? -Operand1 : Operand1;
    mag2      = sign2 ? -Operand2 : Operand2;

    // Product is negated as a full 2*WIDTH unit; a zero divisor leaves the
    // quotient all ones while the remainder sign fix restores raw Operand1
    prod_fix  = sign_q ? -acc_step : acc_step;
    quo_fix   = div0_q ? {WIDTH{1'b1}}
                       : (sign_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0]);
    rem_fix   = rsign_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  // FSM next state, operand capture, iteration and result load
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    sign_d    = sign_q;
    rsign_d   = rsign_q;
    div0_d    = div0_q;
    result1_d = result1_q;
    result2_d = result2_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = COMPUTE;
          count_d  = '0;
          is_div_d = op_is_div;
          sign_d   = sign1 ^ sign2;
          rsign_d  = sign1;
          div0_d   = op_is_div && (Operand2 == '0);
          acc_d    = {{WIDTH{1'b0}}, (op_is_div ? mag1 : mag2)};
          opnd_d   = op_is_div ? mag2 : mag1;
        end
      end
      COMPUTE: begin
        acc_d   = acc_step;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = DONE;
          if (is_div_q) begin
            result1_d = quo_fix;
            result2_d = rem_fix;
          end else begin
            result1_d = prod_fix[WIDTH-1:0];
            result2_d = prod_fix[2*WIDTH-1:WIDTH];
          end
        end
      end
      DONE: begin
        // Start still belongs to the completing instruction here
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous abort of any operation in flight
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      sign_q    <= 1'b0;
      rsign_q   <= 1'b0;
      div0_q    <= 1'b0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      sign_q    <= sign_d;
      rsign_q   <= rsign_d;
      div0_q    <= div0_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;
  assign Busy    = ((state_q == IDLE) && Start) || (state_q == COMPUTE);
  assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_mcycle_sequencer.sv
// tb/tb_mcycle_sequencer.sv - scoreboard bench for the multi-cycle mul/div sequencer
module tb_mcycle_sequencer;
  import mcycle_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESETn = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   MCycleOp = 2'b00;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string        name;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } exp_t;

  exp_t exp_q[$];
  bit   prev_done = 1'b0;

  mcycle_sequencer #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Monitor: every Done pulse pops one expected result and compares it
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (Done === 1'b1) begin
      chk1("done_single_cycle", prev_done, 1'b0);
      chk1("busy_low_in_done", Busy, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1, required no pending operation");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_r1"}, Result1, e.r1);
        chk({e.name, "_r2"}, Result2, e.r2);
      end
    end
    prev_done = Done;
  end

  // Issue one operation, scramble inputs after the Start edge, and time the stall
  task automatic issue(input string name, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e1, input logic [W-1:0] e2,
                       input bit hold);
    exp_t e;
    int   edges;
    int   busy_n;
    bit   seen;
    bit   activity;
    @(negedge CLK);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    e.name = name;
    e.r1   = e1;
    e.r2   = e2;
    exp_q.push_back(e);
    #1;
    chk1({name, "_busy_start"}, Busy, 1'b1);
    edges  = 0;
    busy_n = 1;
    seen   = 1'b0;
    while (edges < 100 && !seen) begin
      @(posedge CLK);
      #1;
      edges++;
      if (edges == 1) begin
        if (!hold) Start = 1'b0;
        Operand1 = ~a;
        Operand2 = ~b;
        MCycleOp = ~op;
      end
      if (Done) seen = 1'b1;
      else if (Busy) busy_n++;
    end
    chk({name, "_done_latency"}, edges, W + 1);
    chk({name, "_busy_cycles"}, busy_n, W + 1);
    @(posedge CLK);
    #1;
    if (hold) begin
      Start = 1'b0;
      #1;
      chk1({name, "_busy_after_hold"}, Busy, 1'b0);
      activity = 1'b0;
      repeat (40) begin
        @(posedge CLK);
        #1;
        if (Busy || Done) activity = 1'b1;
      end
      chk1({name, "_no_restart"}, activity, 1'b0);
    end
  endtask

  initial begin
    #1;
    chk("reset_r1", Result1, '0);
    chk("reset_r2", Result2, '0);
    chk1("reset_done", Done, 1'b0);
    chk1("reset_busy", Busy, 1'b0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;

    issue("umul_max",     MC_UMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    issue("smul_neg",     MC_SMUL, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0);
    issue("sdiv_neg",     MC_SDIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    issue("udiv",         MC_UDIV, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
    issue("udiv_zero",    MC_UDIV, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0);
    issue("sdiv_zero",    MC_SDIV, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);
    issue("smul_minneg",  MC_SMUL, 32'h80000000, 32'd2,        32'h00000000, 32'hFFFFFFFF, 1'b0);
    issue("sdiv_ovf_hold", MC_SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1);
    issue("sdiv_negdiv",  MC_SDIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0);

    repeat (3) @(posedge CLK);
    #1;
    Operand1 = 32'h12345678;
    Operand2 = 32'h9ABCDEF0;
    #1;
    chk("idle_hold_r1", Result1, 32'hFFFFFFFD);
    chk("idle_hold_r2", Result2, 32'd1);

    // Abort a multiply once the iteration count has reached 10
    @(negedge CLK);
    Start    = 1'b1;
    MCycleOp = MC_UMUL;
    Operand1 = 32'hFFFFFFFF;
    Operand2 = 32'hFFFFFFFF;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RESETn = 1'b0;
    #1;
    chk("abort_r1", Result1, '0);
    chk("abort_r2", Result2, '0);
    chk1("abort_done", Done, 1'b0);
    chk1("abort_busy", Busy, 1'b0);
    @(negedge CLK);
    RESETn = 1'b1;

    issue("umul_after_rst", MC_UMUL, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);

    repeat (3) @(posedge CLK);
    #1;
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
